// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, state and control-field encodings for the multicycle control unit
//
// Shared by mc_ctrl_decode and multicycle_control.
//   OP_*     : MIPS opcode field values (IR[31:26])
//   state_e  : 4-bit FSM state encoding, also exported on state_dbg
//   ALU_*    : alu_op codes
//   SRCB_*   : alu_src_b mux selects
//   PCSRC_*  : pc_source mux selects
//   REGDST_* : reg_dst mux selects
//   ctrl_t   : full datapath control word produced by the decoder
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC      = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EX   = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_TRAP      = 4'd13
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       bne;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state-to-control-word decoder
//
// Ports:
//   state_i     : current FSM state
//   opcode_i    : instruction opcode, only consulted in BRANCH (beq vs bne)
//   mem_ready_i : effective memory ready (already forced high when handshaking is off)
//   ctrl_o      : datapath control word; all-zero for IDLE and unknown states
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC only latch on the cycle the fetch actually completes
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                // sw retires on the cycle memory accepts the write
                ctrl_o.instr_done = mem_ready_i;
            end
            ST_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.bne           = (opcode_i == OP_BNE);
                ctrl_o.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            ST_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.instr_done = 1'b1;
            end
            ST_TRAP: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with retired-instruction counter
//
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   opcode           : IR[31:26], stable from DECODE until retirement
//   mem_ready        : memory access completes this cycle
//   pc_write .. bne  : datapath controls, Moore-decoded from the state
//   illegal_op       : high while parked in TRAP
//   instr_done       : one-cycle pulse in the last state of each instruction
//   retired_cnt      : wrapping count of retired instructions
//   state_dbg        : current state encoding
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter bit ENABLE_BNE    = 1'b1,
    parameter bit ENABLE_ADDI   = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic [1:0]       reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             bne,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_rdy;
    ctrl_t            ctrl;

    // Without a handshake every wait state behaves as if memory answered at once
    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .mem_ready_i (mem_rdy),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (mem_rdy) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_BNE:       state_d = ENABLE_BNE ? ST_BRANCH : ST_TRAP;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ENABLE_ADDI ? ST_ADDI_EX : ST_TRAP;
                    default:      state_d = ST_TRAP;
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so one opcode compare picks the path
            ST_MEM_ADDR:  state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  if (mem_rdy) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: if (mem_rdy) state_d = ST_FETCH;
            ST_EXEC:      state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_ADDI_EX:   state_d = ST_ADDI_WB;
            ST_ADDI_WB:   state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign cnt_d = ctrl.instr_done ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign bne           = ctrl.bne;
    assign illegal_op    = ctrl.illegal_op;
    assign instr_done    = ctrl.instr_done;
    assign retired_cnt   = cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [5:0] op_a = '0, op_b = '0;
    logic       mr_a = 1'b0, mr_b = 1'b0;

    logic pw_a, pwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rw_a, asa_a, bne_a, ill_a, dn_a;
    logic [1:0] rd_a, asb_a, aop_a, psrc_a;
    logic [31:0] cnt_a;
    logic [3:0]  st_a;

    logic pw_b, pwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rw_b, asa_b, bne_b, ill_b, dn_b;
    logic [1:0] rd_b, asb_b, aop_b, psrc_b;
    logic [3:0]  cnt_b;
    logic [3:0]  st_b;

    logic [19:0] vec_a, vec_b;
    assign vec_a = {pw_a, pwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rd_a, rw_a,
                    asa_a, asb_a, aop_a, psrc_a, bne_a, ill_a, dn_a};
    assign vec_b = {pw_b, pwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rd_b, rw_b,
                    asa_b, asb_b, aop_b, psrc_b, bne_b, ill_b, dn_b};

    multicycle_control dut_a (
        .clk(clk), .rst(rst_a), .opcode(op_a), .mem_ready(mr_a),
        .pc_write(pw_a), .pc_write_cond(pwc_a), .iord(iord_a), .mem_read(mrd_a),
        .mem_write(mwr_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rd_a),
        .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a),
        .pc_source(psrc_a), .bne(bne_a), .illegal_op(ill_a), .instr_done(dn_a),
        .retired_cnt(cnt_a), .state_dbg(st_a)
    );

    multicycle_control #(.ENABLE_BNE(1'b0), .ENABLE_ADDI(1'b1), .MEM_HANDSHAKE(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(op_b), .mem_ready(mr_b),
        .pc_write(pw_b), .pc_write_cond(pwc_b), .iord(iord_b), .mem_read(mrd_b),
        .mem_write(mwr_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rd_b),
        .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b),
        .pc_source(psrc_b), .bne(bne_b), .illegal_op(ill_b), .instr_done(dn_b),
        .retired_cnt(cnt_b), .state_dbg(st_b)
    );

    typedef struct {
        state_e      st;
        logic        mr;
        logic [5:0]  op;
        logic [19:0] vec;
        int          cnt;
    } entry_t;

    entry_t sb[$];
    int     exp_cnt[2];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word, written from the state table of the control unit
    function automatic logic [19:0] model_vec(input state_e st, input logic mre, input logic [5:0] op);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rw, asa, bn, ill, dn;
        logic [1:0] rd, asb, aop, psrc;
        {pw, pwc, io, mrd, mwr, irw, m2r, rw, asa, bn, ill, dn} = '0;
        {rd, asb, aop, psrc} = '0;
        case (st)
            ST_FETCH:     begin mrd = 1; asb = 2'b01; irw = mre; pw = mre; end
            ST_DECODE:    asb = 2'b11;
            ST_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            ST_MEM_READ:  begin mrd = 1; io = 1; end
            ST_MEM_WB:    begin rw = 1; m2r = 1; dn = 1; end
            ST_MEM_WRITE: begin mwr = 1; io = 1; dn = mre; end
            ST_EXEC:      begin asa = 1; aop = 2'b10; end
            ST_R_WB:      begin rw = 1; rd = 2'b01; dn = 1; end
            ST_BRANCH:    begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; dn = 1;
                                bn = (op == 6'b000101); end
            ST_JUMP:      begin pw = 1; psrc = 2'b10; dn = 1; end
            ST_ADDI_EX:   begin asa = 1; asb = 2'b10; end
            ST_ADDI_WB:   begin rw = 1; dn = 1; end
            ST_TRAP:      ill = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, bn, ill, dn};
    endfunction

    task automatic push_cycle(input int sel, input state_e st, input logic mr, input logic [5:0] op);
        entry_t e;
        logic   mre;
        mre   = (sel == 0) ? mr : 1'b1;
        e.st  = st;
        e.mr  = mr;
        e.op  = op;
        e.vec = model_vec(st, mre, op);
        e.cnt = exp_cnt[sel];
        sb.push_back(e);
        if (e.vec[0]) exp_cnt[sel] = exp_cnt[sel] + 1;
    endtask

    // dut_a: handshake on, bne/addi enabled. dut_b: no handshake (mem_ready held 0), bne disabled.
    task automatic push_instr(input int sel, input logic [5:0] op, input int fw, input int mw);
        bit   hs;
        logic rl;
        hs = (sel == 0);
        rl = hs;
        if (hs) for (int i = 0; i < fw; i++) push_cycle(sel, ST_FETCH, 1'b0, op);
        push_cycle(sel, ST_FETCH, rl, op);
        push_cycle(sel, ST_DECODE, rl, op);
        case (op)
            6'b100011: begin
                push_cycle(sel, ST_MEM_ADDR, rl, op);
                if (hs) for (int i = 0; i < mw; i++) push_cycle(sel, ST_MEM_READ, 1'b0, op);
                push_cycle(sel, ST_MEM_READ, rl, op);
                push_cycle(sel, ST_MEM_WB, rl, op);
            end
            6'b101011: begin
                push_cycle(sel, ST_MEM_ADDR, rl, op);
                if (hs) for (int i = 0; i < mw; i++) push_cycle(sel, ST_MEM_WRITE, 1'b0, op);
                push_cycle(sel, ST_MEM_WRITE, rl, op);
            end
            6'b000000: begin
                push_cycle(sel, ST_EXEC, rl, op);
                push_cycle(sel, ST_R_WB, rl, op);
            end
            6'b000100: push_cycle(sel, ST_BRANCH, rl, op);
            6'b000101: begin
                if (hs) push_cycle(sel, ST_BRANCH, rl, op);
                else for (int i = 0; i < 3; i++) push_cycle(sel, ST_TRAP, rl, op);
            end
            6'b000010: push_cycle(sel, ST_JUMP, rl, op);
            6'b001000: begin
                push_cycle(sel, ST_ADDI_EX, rl, op);
                push_cycle(sel, ST_ADDI_WB, rl, op);
            end
            default: for (int i = 0; i < 3; i++) push_cycle(sel, ST_TRAP, rl, op);
        endcase
    endtask

    // Pop n expected cycles (all when n < 0), drive each cycle's stimulus, compare mid-cycle
    task automatic run(input int sel, input int n);
        for (int i = 0; (n < 0 || i < n) && sb.size() > 0; i++) begin
            entry_t e;
            e = sb.pop_front();
            @(negedge clk);
            if (sel == 0) begin op_a = e.op; mr_a = e.mr; end
            else          begin op_b = e.op; mr_b = e.mr; end
            #1;
            if (sel == 0) begin
                check("state_a", 32'(st_a), 32'(e.st));
                check("ctrl_a", 32'(vec_a), 32'(e.vec));
                check("cnt_a", cnt_a, 32'(e.cnt));
            end else begin
                check("state_b", 32'(st_b), 32'(e.st));
                check("ctrl_b", 32'(vec_b), 32'(e.vec));
                check("cnt_b", {28'd0, cnt_b}, 32'(e.cnt % 16));
            end
        end
    endtask

    // Asserts reset away from any clock edge, checks the immediate effect, releases on the next negedge
    task automatic do_reset(input int sel);
        #1;
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        #1;
        if (sel == 0) begin
            check("rst_ctrl_a", 32'(vec_a), 32'd0);
            check("rst_state_a", 32'(st_a), 32'(ST_IDLE));
            check("rst_cnt_a", cnt_a, 32'd0);
        end else begin
            check("rst_ctrl_b", 32'(vec_b), 32'd0);
            check("rst_state_b", 32'(st_b), 32'(ST_IDLE));
            check("rst_cnt_b", {28'd0, cnt_b}, 32'd0);
        end
        @(negedge clk);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        #1;
        if (sel == 0) check("rel_state_a", 32'(st_a), 32'(ST_IDLE));
        else          check("rel_state_b", 32'(st_b), 32'(ST_IDLE));
        sb.delete();
        exp_cnt[sel] = 0;
    endtask

    initial begin
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(negedge clk);

        do_reset(0);
        push_instr(0, 6'b100011, 1, 0); run(0, -1);   // lw, one fetch wait
        push_instr(0, 6'b101011, 0, 3); run(0, -1);   // sw, 3 write waits
        push_instr(0, 6'b000000, 0, 0); run(0, -1);   // R-type
        push_instr(0, 6'b001000, 2, 0); run(0, -1);   // addi, fetch waits
        push_instr(0, 6'b000100, 0, 0); run(0, -1);   // beq
        push_instr(0, 6'b000101, 0, 0); run(0, -1);   // bne
        push_instr(0, 6'b000010, 0, 0); run(0, -1);   // j
        push_instr(0, 6'b100011, 0, 2); run(0, -1);   // lw, read waits

        push_instr(0, 6'b100011, 0, 3); run(0, 4);    // stop inside MEM_READ
        do_reset(0);
        push_instr(0, 6'b000010, 0, 0); run(0, -1);   // FETCH right after release

        push_instr(0, 6'b111111, 0, 0); run(0, -1);   // illegal -> TRAP, count held
        do_reset(0);

        do_reset(1);
        push_instr(1, 6'b100011, 0, 0); run(1, -1);
        push_instr(1, 6'b101011, 0, 0); run(1, -1);
        push_instr(1, 6'b001000, 0, 0); run(1, -1);
        for (int k = 0; k < 16; k++) begin
            push_instr(1, 6'b000010, 0, 0);
            run(1, -1);
        end
        push_instr(1, 6'b000101, 0, 0); run(1, -1);   // bne disabled -> TRAP
        check("wrap_b", {28'd0, cnt_b}, 32'(19 % 16));
        check("trap_hold_b", {31'd0, ill_b}, 32'd1);
        do_reset(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
